// File: rtl/autosa_mcif_csb_cfg_regs.sv
// ---------------------------------------------------------------------------
// autosa_mcif_csb_cfg_regs
//
// Double-buffered MCIF configuration register file. CSB writes land in shadow
// registers. The active weights and outstanding limits seen by the MCIF
// read/write arbiters change only on a commit, and a commit is taken only
// while the MCIF is idle.
//
// Ports
//   autosa_core_clk   clock
//   autosa_core_rstn  asynchronous active-low reset
//   reg_offset        byte offset of the CSB access (12 bits)
//   reg_wr_en         write strobe, one word per cycle
//   reg_wr_data       write data (32 bits)
//   reg_rd_en         read strobe
//   reg_rd_data       registered read data (32 bits)
//   reg_rd_valid      one-cycle pulse, reg_rd_data is valid
//   idle              MCIF has no outstanding transactions
//   rd_weight         active read weights, client i at [8i+7:8i]
//   wr_weight         active write weights, client i at [8i+7:8i]
//   rd_os_cnt         active read outstanding limit
//   wr_os_cnt         active write outstanding limit
//   commit_done       one-cycle pulse when the active set is updated
//
// Word map, relative to BASE_OFFSET (R = ceil(rd clients/4),
// W = ceil(wr clients/4)):
//   4k          RD_WEIGHT_k   byte j = shadow weight of client 4k+j
//   4(R+k)      WR_WEIGHT_k   same packing
//   4(R+W)      OS_CNT        [7:0] rd, [15:8] wr
//   4(R+W+1)    CTRL          [0] commit (write-1, reads 0), [1] auto_commit
//   4(R+W+2)    STATUS        [0] pending, [1] inv_wr_err (W1C),
//                             [2] rowr_err (W1C), [8] idle
// ---------------------------------------------------------------------------
module autosa_mcif_csb_cfg_regs #(
    parameter int          NUM_RD_CLIENTS = 12,
    parameter int          NUM_WR_CLIENTS = 8,
    parameter logic [11:0] BASE_OFFSET    = 12'h000,
    parameter logic [7:0]  RST_WEIGHT     = 8'h01,
    parameter logic [7:0]  RST_OS_CNT     = 8'hFF
) (
    input  logic                          autosa_core_clk,
    input  logic                          autosa_core_rstn,
    input  logic [11:0]                   reg_offset,
    input  logic                          reg_wr_en,
    input  logic [31:0]                   reg_wr_data,
    input  logic                          reg_rd_en,
    output logic [31:0]                   reg_rd_data,
    output logic                          reg_rd_valid,
    input  logic                          idle,
    output logic [8*NUM_RD_CLIENTS-1:0]   rd_weight,
    output logic [8*NUM_WR_CLIENTS-1:0]   wr_weight,
    output logic [7:0]                    rd_os_cnt,
    output logic [7:0]                    wr_os_cnt,
    output logic                          commit_done
);

    localparam int R        = (NUM_RD_CLIENTS + 3) / 4;
    localparam int W        = (NUM_WR_CLIENTS + 3) / 4;
    localparam int RD_PAD_W = 32 * R;
    localparam int WR_PAD_W = 32 * W;

    localparam logic [9:0] IDX_OS   = 10'(R + W);
    localparam logic [9:0] IDX_CTRL = 10'(R + W + 1);
    localparam logic [9:0] IDX_STAT = 10'(R + W + 2);

    // ---------------- address decode ----------------
    // The offset must be at or above the base, word aligned, and inside the
    // map; anything else is unmapped (full 12-bit compare, no aliasing).
    logic [11:0] rel_offset;
    logic [9:0]  addr_idx;
    logic        addr_hit;

    assign rel_offset = reg_offset - BASE_OFFSET;
    assign addr_idx   = rel_offset[11:2];
    assign addr_hit   = (reg_offset >= BASE_OFFSET) &&
                        (rel_offset[1:0] == 2'b00) &&
                        (addr_idx <= IDX_STAT);

    logic wr_hit, shadow_wr, ctrl_wr, stat_wr, inv_wr;

    assign wr_hit    = reg_wr_en & addr_hit;
    assign shadow_wr = wr_hit & (addr_idx < IDX_CTRL);   // weight or OS_CNT word
    assign ctrl_wr   = wr_hit & (addr_idx == IDX_CTRL);
    assign stat_wr   = wr_hit & (addr_idx == IDX_STAT);
    assign inv_wr    = reg_wr_en & ~addr_hit;

    // ---------------- commit control ----------------
    logic commit_pending;
    logic auto_commit;
    logic inv_wr_err;
    logic rowr_err;
    logic commit_fire;

    // A shadow write in the same cycle defers the commit so the active set
    // never mixes old and new values of one word.
    assign commit_fire = commit_pending & idle & ~shadow_wr;

    // ---------------- per-client weights ----------------
    logic [8*NUM_RD_CLIENTS-1:0] shadow_rd_flat;
    logic [8*NUM_WR_CLIENTS-1:0] shadow_wr_flat;

    for (genvar i = 0; i < NUM_RD_CLIENTS; i++) begin : g_rd
        localparam logic [9:0] WORD = 10'(i / 4);
        localparam int         LANE = i % 4;
        logic [7:0] shadow_q;
        logic [7:0] active_q;

        // NOTE: every register here, including each element of the weight
        // bank, has an explicit reset value; the arbiters must see a defined
        // weight before software configures anything.
        always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
            if (!autosa_core_rstn) begin
                shadow_q <= RST_WEIGHT;
                active_q <= RST_WEIGHT;
            end else begin
                if (wr_hit && (addr_idx == WORD))
                    shadow_q <= reg_wr_data[8*LANE +: 8];
                if (commit_fire)
                    active_q <= shadow_q;
            end
        end

        assign shadow_rd_flat[8*i +: 8] = shadow_q;
        assign rd_weight[8*i +: 8]      = active_q;
    end

    for (genvar i = 0; i < NUM_WR_CLIENTS; i++) begin : g_wr
        localparam logic [9:0] WORD = 10'(R + i / 4);
        localparam int         LANE = i % 4;
        logic [7:0] shadow_q;
        logic [7:0] active_q;

        always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
            if (!autosa_core_rstn) begin
                shadow_q <= RST_WEIGHT;
                active_q <= RST_WEIGHT;
            end else begin
                if (wr_hit && (addr_idx == WORD))
                    shadow_q <= reg_wr_data[8*LANE +: 8];
                if (commit_fire)
                    active_q <= shadow_q;
            end
        end

        assign shadow_wr_flat[8*i +: 8] = shadow_q;
        assign wr_weight[8*i +: 8]      = active_q;
    end

    // Zero-extend to whole words so bytes beyond the client count read 0.
    logic [RD_PAD_W-1:0] shadow_rd_pad;
    logic [WR_PAD_W-1:0] shadow_wr_pad;

    assign shadow_rd_pad = RD_PAD_W'(shadow_rd_flat);
    assign shadow_wr_pad = WR_PAD_W'(shadow_wr_flat);

    // ---------------- read mux ----------------
    logic [7:0]  shadow_rd_os;
    logic [7:0]  shadow_wr_os;
    logic [31:0] rd_word;

    // NOTE: rd_word gets a default before any branch, so no path through
    // this block leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < R; k++)
            if (addr_idx == 10'(k))
                rd_word = shadow_rd_pad[32*k +: 32];
        for (int k = 0; k < W; k++)
            if (addr_idx == 10'(R + k))
                rd_word = shadow_wr_pad[32*k +: 32];
        if (addr_idx == IDX_OS)
            rd_word = {16'h0000, shadow_wr_os, shadow_rd_os};
        if (addr_idx == IDX_CTRL)
            rd_word = {30'h0, auto_commit, 1'b0};
        if (addr_idx == IDX_STAT)
            rd_word = {23'h0, idle, 5'h00, rowr_err, inv_wr_err, commit_pending};
        if (!addr_hit)
            rd_word = '0;
    end

    // ---------------- control, status, OS counts, read port ----------------
    logic pending_set;
    logic rowr_set;

    assign pending_set = (ctrl_wr & reg_wr_data[0]) | (auto_commit & shadow_wr);
    assign rowr_set    = stat_wr & (reg_wr_data[0] | (|(reg_wr_data & ~32'h0000_0006)));

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values; this is what makes a same-cycle read return
    // the pre-write word and lets set-wins priority be written as plain OR.
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            shadow_rd_os   <= RST_OS_CNT;
            shadow_wr_os   <= RST_OS_CNT;
            rd_os_cnt      <= RST_OS_CNT;
            wr_os_cnt      <= RST_OS_CNT;
            commit_pending <= 1'b0;
            auto_commit    <= 1'b0;
            inv_wr_err     <= 1'b0;
            rowr_err       <= 1'b0;
            commit_done    <= 1'b0;
            reg_rd_valid   <= 1'b0;
            reg_rd_data    <= '0;
        end else begin
            if (wr_hit && (addr_idx == IDX_OS)) begin
                shadow_rd_os <= reg_wr_data[7:0];
                shadow_wr_os <= reg_wr_data[15:8];
            end
            if (commit_fire) begin
                rd_os_cnt <= shadow_rd_os;
                wr_os_cnt <= shadow_wr_os;
            end
            if (ctrl_wr)
                auto_commit <= reg_wr_data[1];

            commit_pending <= pending_set | (commit_pending & ~commit_fire);
            inv_wr_err     <= inv_wr | (inv_wr_err & ~(stat_wr & reg_wr_data[1]));
            rowr_err       <= rowr_set | (rowr_err & ~(stat_wr & reg_wr_data[2]));
            commit_done    <= commit_fire;

            reg_rd_valid <= reg_rd_en;
            if (reg_rd_en)
                reg_rd_data <= rd_word;
        end
    end

endmodule

// File: tb/tb_autosa_mcif_csb_cfg_regs.sv
// ---------------------------------------------------------------------------
// tb_autosa_mcif_csb_cfg_regs
//
// Directed bench. The default-parameter instance (12 rd / 8 wr clients) is
// exercised through a table of write/readback vectors and hand-written
// commit, auto-commit and error sequences. A second instance with 5 read
// clients covers partial-word packing and reset during a pending commit.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_autosa_mcif_csb_cfg_regs;

    // Map for the default instance: R=3, W=2.
    localparam logic [11:0] A_RD0  = 12'h000;
    localparam logic [11:0] A_RD1  = 12'h004;
    localparam logic [11:0] A_RD2  = 12'h008;
    localparam logic [11:0] A_WR0  = 12'h00C;
    localparam logic [11:0] A_WR1  = 12'h010;
    localparam logic [11:0] A_OS   = 12'h014;
    localparam logic [11:0] A_CTRL = 12'h018;
    localparam logic [11:0] A_STAT = 12'h01C;

    // Map for the 5-client instance: R=2, W=2.
    localparam logic [11:0] B_RD1  = 12'h004;
    localparam logic [11:0] B_CTRL = 12'h014;
    localparam logic [11:0] B_STAT = 12'h018;

    logic        autosa_core_clk;
    logic        autosa_core_rstn;
    logic        rst5_n;

    logic [11:0] reg_offset;
    logic        reg_wr_en;
    logic [31:0] reg_wr_data;
    logic        reg_rd_en;
    logic [31:0] reg_rd_data;
    logic        reg_rd_valid;
    logic        idle;
    logic [95:0] rd_weight;
    logic [63:0] wr_weight;
    logic [7:0]  rd_os_cnt;
    logic [7:0]  wr_os_cnt;
    logic        commit_done;

    logic [11:0] offset5;
    logic        wr_en5;
    logic [31:0] wr_data5;
    logic        rd_en5;
    logic [31:0] rd_data5;
    logic        rd_valid5;
    logic        idle5;
    logic [39:0] rd_weight5;
    logic [63:0] wr_weight5;
    logic [7:0]  rd_os_cnt5;
    logic [7:0]  wr_os_cnt5;
    logic        commit_done5;

    int n_checks = 0;
    int n_bad    = 0;

    autosa_mcif_csb_cfg_regs dut (
        .autosa_core_clk  (autosa_core_clk),
        .autosa_core_rstn (autosa_core_rstn),
        .reg_offset       (reg_offset),
        .reg_wr_en        (reg_wr_en),
        .reg_wr_data      (reg_wr_data),
        .reg_rd_en        (reg_rd_en),
        .reg_rd_data      (reg_rd_data),
        .reg_rd_valid     (reg_rd_valid),
        .idle             (idle),
        .rd_weight        (rd_weight),
        .wr_weight        (wr_weight),
        .rd_os_cnt        (rd_os_cnt),
        .wr_os_cnt        (wr_os_cnt),
        .commit_done      (commit_done)
    );

    autosa_mcif_csb_cfg_regs #(.NUM_RD_CLIENTS(5)) dut5 (
        .autosa_core_clk  (autosa_core_clk),
        .autosa_core_rstn (rst5_n),
        .reg_offset       (offset5),
        .reg_wr_en        (wr_en5),
        .reg_wr_data      (wr_data5),
        .reg_rd_en        (rd_en5),
        .reg_rd_data      (rd_data5),
        .reg_rd_valid     (rd_valid5),
        .idle             (idle5),
        .rd_weight        (rd_weight5),
        .wr_weight        (wr_weight5),
        .rd_os_cnt        (rd_os_cnt5),
        .wr_os_cnt        (wr_os_cnt5),
        .commit_done      (commit_done5)
    );

    initial autosa_core_clk = 1'b0;
    always #5 autosa_core_clk = ~autosa_core_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic csb_wr(input logic [11:0] off, input logic [31:0] data);
        @(negedge autosa_core_clk);
        reg_offset  = off;
        reg_wr_data = data;
        reg_wr_en   = 1'b1;
        @(negedge autosa_core_clk);
        reg_wr_en   = 1'b0;
    endtask

    task automatic csb_rd(input logic [11:0] off, output logic [31:0] data, output logic valid);
        @(negedge autosa_core_clk);
        reg_offset = off;
        reg_rd_en  = 1'b1;
        @(negedge autosa_core_clk);
        reg_rd_en  = 1'b0;
        data  = reg_rd_data;
        valid = reg_rd_valid;
    endtask

    task automatic csb5_wr(input logic [11:0] off, input logic [31:0] data);
        @(negedge autosa_core_clk);
        offset5  = off;
        wr_data5 = data;
        wr_en5   = 1'b1;
        @(negedge autosa_core_clk);
        wr_en5   = 1'b0;
    endtask

    task automatic csb5_rd(input logic [11:0] off, output logic [31:0] data);
        @(negedge autosa_core_clk);
        offset5 = off;
        rd_en5  = 1'b1;
        @(negedge autosa_core_clk);
        rd_en5  = 1'b0;
        data = rd_data5;
    endtask

    typedef struct {
        logic [11:0] off;
        logic        do_wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [31:0] d;
        logic        v;
        logic        hold_bad;

        vecs[0] = '{A_RD0,  1'b1, 32'h0403_0201, 32'h0403_0201};
        vecs[1] = '{A_RD1,  1'b1, 32'h0807_0605, 32'h0807_0605};
        vecs[2] = '{A_RD2,  1'b1, 32'hC0B0_A090, 32'hC0B0_A090};
        vecs[3] = '{A_WR0,  1'b1, 32'h1122_3344, 32'h1122_3344};
        vecs[4] = '{A_WR1,  1'b1, 32'h5566_7788, 32'h5566_7788};
        vecs[5] = '{A_OS,   1'b1, 32'hABCD_5566, 32'h0000_5566};
        vecs[6] = '{A_CTRL, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{12'h020, 1'b0, 32'h0,        32'h0000_0000};
        vecs[8] = '{12'h002, 1'b0, 32'h0,        32'h0000_0000};
        vecs[9] = '{12'h800, 1'b0, 32'h0,        32'h0000_0000};

        autosa_core_rstn = 1'b0;
        rst5_n      = 1'b0;
        reg_offset  = '0;
        reg_wr_en   = 1'b0;
        reg_wr_data = '0;
        reg_rd_en   = 1'b0;
        idle        = 1'b1;
        offset5     = '0;
        wr_en5      = 1'b0;
        wr_data5    = '0;
        rd_en5      = 1'b0;
        idle5       = 1'b1;
        repeat (3) @(negedge autosa_core_clk);
        autosa_core_rstn = 1'b1;
        rst5_n           = 1'b1;
        @(negedge autosa_core_clk);

        // ---------------- reset state ----------------
        check("rst_rd_weight",   rd_weight,   {12{8'h01}});
        check("rst_wr_weight",   wr_weight,   {8{8'h01}});
        check("rst_rd_os_cnt",   rd_os_cnt,   8'hFF);
        check("rst_wr_os_cnt",   wr_os_cnt,   8'hFF);
        check("rst_commit_done", commit_done, 1'b0);
        check("rst_rd_valid",    reg_rd_valid, 1'b0);
        check("rst_rd_data",     reg_rd_data, 32'h0);

        csb_rd(A_RD0, d, v);
        check("rst_read_rd0",       d, 32'h0101_0101);
        check("rst_read_rd0_valid", v, 1'b1);
        @(negedge autosa_core_clk);
        check("rd_valid_pulse", reg_rd_valid, 1'b0);
        check("rd_data_holds",  reg_rd_data,  32'h0101_0101);
        csb_rd(A_OS, d, v);
        check("rst_read_os", d, 32'h0000_FFFF);

        // ---------------- table: shadow writes and readbacks ----------------
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr)
                csb_wr(vecs[i].off, vecs[i].wdata);
            csb_rd(vecs[i].off, d, v);
            check($sformatf("vec%0d_rd_data", i), d, vecs[i].exp_rd);
            check($sformatf("vec%0d_rd_valid", i), v, 1'b1);
        end
        check("shadow_only_rd_weight", rd_weight, {12{8'h01}});
        check("shadow_only_os",        {wr_os_cnt, rd_os_cnt}, 16'hFFFF);

        // ---------------- explicit commit while idle ----------------
        csb_wr(A_CTRL, 32'h1);
        check("commit_not_yet", rd_weight[31:0], 32'h0101_0101);
        @(negedge autosa_core_clk);
        check("commit_rd_weight",  rd_weight, {32'hC0B0_A090, 32'h0807_0605, 32'h0403_0201});
        check("commit_wr_weight",  wr_weight, {32'h5566_7788, 32'h1122_3344});
        check("commit_os",         {wr_os_cnt, rd_os_cnt}, 16'h5566);
        check("commit_done_pulse", commit_done, 1'b1);
        @(negedge autosa_core_clk);
        check("commit_done_low", commit_done, 1'b0);
        csb_rd(A_STAT, d, v);
        check("status_after_commit", d, 32'h0000_0100);
        csb_rd(A_CTRL, d, v);
        check("ctrl_commit_reads0", d, 32'h0);

        // ---------------- commit held while busy ----------------
        csb_wr(A_RD0, 32'hDEAD_BEEF);
        idle = 1'b0;
        csb_wr(A_CTRL, 32'h1);
        hold_bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge autosa_core_clk);
            if (commit_done !== 1'b0 || rd_weight[31:0] !== 32'h0403_0201)
                hold_bad = 1'b1;
        end
        check("busy_hold_50", hold_bad, 1'b0);
        csb_rd(A_STAT, d, v);
        check("busy_status_pending", d, 32'h0000_0001);
        idle = 1'b1;
        @(negedge autosa_core_clk);
        check("busy_release_weight", rd_weight[31:0], 32'hDEAD_BEEF);
        check("busy_release_done",   commit_done, 1'b1);
        csb_rd(A_STAT, d, v);
        check("busy_release_status", d, 32'h0000_0100);

        // ---------------- shadow write defers a pending commit ----------------
        @(negedge autosa_core_clk);
        reg_offset  = A_CTRL;
        reg_wr_data = 32'h1;
        reg_wr_en   = 1'b1;
        @(negedge autosa_core_clk);
        reg_offset  = A_RD1;
        reg_wr_data = 32'h0A0B_0C0D;
        @(negedge autosa_core_clk);
        reg_wr_en   = 1'b0;
        check("defer_no_done",   commit_done, 1'b0);
        check("defer_old_value", rd_weight[63:32], 32'h0807_0605);
        @(negedge autosa_core_clk);
        check("defer_done",      commit_done, 1'b1);
        check("defer_new_value", rd_weight[63:32], 32'h0A0B_0C0D);

        // ---------------- auto-commit ----------------
        csb_wr(A_CTRL, 32'h2);
        csb_rd(A_CTRL, d, v);
        check("ctrl_auto_readback", d, 32'h0000_0002);
        csb_wr(A_OS, 32'h0000_1020);
        check("auto_not_yet", rd_os_cnt, 8'h66);
        @(negedge autosa_core_clk);
        check("auto_rd_os",   rd_os_cnt, 8'h20);
        check("auto_wr_os",   wr_os_cnt, 8'h10);
        check("auto_done",    commit_done, 1'b1);
        csb_wr(A_CTRL, 32'h0);

        // ---------------- error status ----------------
        csb_wr(12'hFFC, 32'h1234_5678);
        csb_rd(A_STAT, d, v);
        check("inv_wr_status", d, 32'h0000_0102);
        csb_rd(A_RD2, d, v);
        check("inv_wr_no_side_effect", d, 32'hC0B0_A090);
        csb_wr(A_STAT, 32'h2);
        csb_rd(A_STAT, d, v);
        check("inv_wr_w1c", d, 32'h0000_0100);
        csb_wr(A_STAT, 32'h1);
        csb_rd(A_STAT, d, v);
        check("rowr_set_bit0", d, 32'h0000_0104);
        csb_wr(A_STAT, 32'h4);
        csb_rd(A_STAT, d, v);
        check("rowr_w1c", d, 32'h0000_0100);
        csb_wr(A_STAT, 32'h5);
        csb_rd(A_STAT, d, v);
        check("rowr_set_wins", d, 32'h0000_0104);
        csb_wr(A_STAT, 32'h4);
        csb_wr(A_STAT, 32'h100);
        csb_rd(A_STAT, d, v);
        check("rowr_set_high_bit", d, 32'h0000_0104);

        // ---------------- read and write to the same word ----------------
        @(negedge autosa_core_clk);
        reg_offset  = A_RD2;
        reg_wr_data = 32'h1234_5678;
        reg_wr_en   = 1'b1;
        reg_rd_en   = 1'b1;
        @(negedge autosa_core_clk);
        reg_wr_en   = 1'b0;
        reg_rd_en   = 1'b0;
        check("rw_same_pre_write", reg_rd_data, 32'hC0B0_A090);
        csb_rd(A_RD2, d, v);
        check("rw_same_post_write", d, 32'h1234_5678);

        // ---------------- 5 read clients ----------------
        csb5_wr(B_RD1, 32'hFFFF_FF07);
        csb5_rd(B_RD1, d);
        check("c5_partial_word", d, 32'h0000_0007);
        idle5 = 1'b0;
        csb5_wr(B_CTRL, 32'h1);
        csb5_rd(B_STAT, d);
        check("c5_pending", d, 32'h0000_0001);
        check("c5_active_unchanged", rd_weight5[39:32], 8'h01);
        rst5_n = 1'b0;
        @(negedge autosa_core_clk);
        check("c5_rst_weights", rd_weight5, {5{8'h01}});
        rst5_n = 1'b1;
        idle5  = 1'b1;
        hold_bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge autosa_core_clk);
            if (commit_done5 !== 1'b0) hold_bad = 1'b1;
        end
        check("c5_no_commit_after_rst", hold_bad, 1'b0);
        check("c5_weights_after_rst",   rd_weight5, {5{8'h01}});
        csb5_rd(B_STAT, d);
        check("c5_status_after_rst", d, 32'h0000_0100);
        csb5_rd(B_RD1, d);
        check("c5_shadow_after_rst", d, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
